// File: rtl/nfa_pkg.sv
// nfa_pkg: shared types for the NFA stream engine.
//   start_mode_e : per-STE start behaviour (none / start-of-data / all-input)
//   cfg_sel_e    : configuration target selector
//   eng_state_e  : engine FSM state, also exported on dbg_state
//   interval_t   : one inclusive match interval {en, hi, lo}
// Interval bounds are stored at NFA_SYM_W_MAX bits; narrower symbols are
// zero-extended before comparison, so SYM_W must not exceed that width.
package nfa_pkg;

  localparam int NFA_SYM_W_MAX = 16;

  typedef enum logic [1:0] {
    SM_NONE = 2'd0,
    SM_SOD  = 2'd1,
    SM_ALL  = 2'd2
  } start_mode_e;

  typedef enum logic [1:0] {
    CS_INT  = 2'd0,
    CS_PRED = 2'd1,
    CS_ATTR = 2'd2
  } cfg_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } eng_state_e;

  typedef struct packed {
    logic                     en;
    logic [NFA_SYM_W_MAX-1:0] hi;
    logic [NFA_SYM_W_MAX-1:0] lo;
  } interval_t;

  // Unsigned inclusive test; an interval with lo > hi can never hit.
  function automatic logic interval_hit(interval_t iv, logic [NFA_SYM_W_MAX-1:0] sym);
    return iv.en && (iv.lo <= sym) && (sym <= iv.hi);
  endfunction

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/nfa_stream_engine_fifo.sv
// nfa_rpt_fifo: synchronous first-word-fall-through FIFO for report records.
//   clk_i, reset_i  : clock, synchronous active-high reset (empties the FIFO)
//   push_i          : write push_data_i (ignored while full)
//   pop_i           : consume the head entry (ignored while empty)
//   pop_data_o      : head entry, valid whenever empty_o is low
//   empty_o, full_o : occupancy flags, both derived from the registered count
// DEPTH must be a power of two so the pointers wrap naturally.
module nfa_rpt_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign empty_o    = (cnt_q == '0);
  assign full_o     = (cnt_q == (AW+1)'(DEPTH));
  assign do_push    = push_i & ~full_o;
  assign do_pop     = pop_i & ~empty_o;
  assign pop_data_o = mem_q[rd_q];

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= push_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/nfa_stream_engine.sv
// nfa_stream_engine: runtime-programmable homogeneous NFA over a symbol stream.
//   cfg_*      : configuration port; honoured only while IDLE, otherwise (or
//                for cfg_sel=3) the write is dropped and cfg_err pulses next cycle
//   sym_*      : input symbol stream
//   rpt_*      : time-stamped report records {rpt_ofs, rpt_vec} from a FWFT FIFO
//   active     : registered active-state vector
//   busy, done : engine not IDLE / one-cycle end-of-stream pulse
//   dbg_state  : current FSM state
// Handshakes: a transfer happens on a rising edge where valid & ready are both
// high. Producers hold data stable while valid is high and not accepted;
// ready never depends combinationally on valid.
module nfa_stream_engine
  import nfa_pkg::*;
#(
  parameter int N_STE      = 16,
  parameter int SYM_W      = 8,
  parameter int N_INT      = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int OFS_W      = 32,
  localparam int STE_W     = $clog2(N_STE),
  localparam int INT_W     = $clog2(N_INT),
  localparam int CFG_W     = max3(2*SYM_W+1, N_STE, 3)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_sel,
  input  logic [STE_W-1:0]  cfg_ste,
  input  logic [INT_W-1:0]  cfg_int,
  input  logic [CFG_W-1:0]  cfg_wdata,
  output logic              cfg_err,
  input  logic              sym_valid,
  output logic              sym_ready,
  input  logic [SYM_W-1:0]  sym_data,
  input  logic              sym_last,
  output logic              rpt_valid,
  input  logic              rpt_ready,
  output logic [OFS_W-1:0]  rpt_ofs,
  output logic [N_STE-1:0]  rpt_vec,
  output logic [N_STE-1:0]  active,
  output logic              busy,
  output logic              done,
  output eng_state_e        dbg_state
);

  // Configuration storage
  interval_t        int_q  [N_STE][N_INT];
  logic [N_STE-1:0] pred_q [N_STE];
  start_mode_e      mode_q [N_STE];
  logic [N_STE-1:0] rep_q;

  // Engine state
  eng_state_e       state_q;
  logic [N_STE-1:0] active_q;
  logic [OFS_W-1:0] ofs_q;
  logic             done_q;
  logic             cfg_err_q;

  logic                     cfg_ok;
  interval_t                iv_w;
  logic [NFA_SYM_W_MAX-1:0] sym_ext;
  logic                     sod;
  logic [N_STE-1:0]         match_vec, enable_vec, act_nx, rpt_d;
  logic [OFS_W-1:0]         cur_ofs;
  logic                     accept, push, pop;
  logic                     fifo_empty, fifo_full;
  logic [OFS_W+N_STE-1:0]   fifo_dout;

  assign cfg_ok = cfg_we & (state_q == ST_IDLE) & (cfg_sel != 2'd3);

  always_comb begin
    iv_w                = '0;
    iv_w.lo[SYM_W-1:0]  = cfg_wdata[SYM_W-1:0];
    iv_w.hi[SYM_W-1:0]  = cfg_wdata[2*SYM_W-1:SYM_W];
    iv_w.en             = cfg_wdata[2*SYM_W];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rep_q <= '0;
      for (int i = 0; i < N_STE; i++) begin
        pred_q[i] <= '0;
        mode_q[i] <= SM_NONE;
        for (int k = 0; k < N_INT; k++) int_q[i][k] <= '0;
      end
    end else if (cfg_ok) begin
      case (cfg_sel_e'(cfg_sel))
        CS_INT:  int_q[cfg_ste][cfg_int] <= iv_w;
        CS_PRED: pred_q[cfg_ste] <= cfg_wdata[N_STE-1:0];
        CS_ATTR: begin
          mode_q[cfg_ste] <= start_mode_e'(cfg_wdata[1:0]);
          rep_q[cfg_ste]  <= cfg_wdata[2];
        end
        default: ;
      endcase
    end
  end

  // Next active vector for the symbol currently on sym_data.
  // Start-of-data is asserted only for the first symbol, i.e. while IDLE.
  always_comb begin
    sym_ext               = '0;
    sym_ext[SYM_W-1:0]    = sym_data;
    sod                   = (state_q == ST_IDLE);
    match_vec             = '0;
    enable_vec            = '0;
    for (int i = 0; i < N_STE; i++) begin
      for (int k = 0; k < N_INT; k++) begin
        match_vec[i] = match_vec[i] | interval_hit(int_q[i][k], sym_ext);
      end
      enable_vec[i] = (|(active_q & pred_q[i])) |
                      (sod & (mode_q[i] == SM_SOD)) |
                      (mode_q[i] == SM_ALL);
    end
    act_nx = match_vec & enable_vec;
    rpt_d  = act_nx & rep_q;
  end

  // The first symbol of a stream always carries offset 0.
  assign cur_ofs   = (state_q == ST_IDLE) ? '0 : ofs_q;
  assign sym_ready = ((state_q == ST_IDLE) | (state_q == ST_STREAM)) & ~fifo_full;
  assign accept    = sym_valid & sym_ready;
  assign push      = accept & (|rpt_d);
  assign pop       = rpt_valid & rpt_ready;

  nfa_rpt_fifo #(
    .WIDTH (OFS_W + N_STE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .reset_i     (reset),
    .push_i      (push),
    .push_data_i ({cur_ofs, rpt_d}),
    .pop_i       (pop),
    .pop_data_o  (fifo_dout),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      active_q  <= '0;
      ofs_q     <= '0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= cfg_we & ~cfg_ok;
      case (state_q)
        ST_IDLE, ST_STREAM: begin
          if (accept) begin
            active_q <= act_nx;
            ofs_q    <= cur_ofs + OFS_W'(1);
            state_q  <= sym_last ? ST_DRAIN : ST_STREAM;
          end
        end
        ST_DRAIN: begin
          // Hold the final active vector until the collector has every record.
          if (fifo_empty) begin
            done_q   <= 1'b1;
            active_q <= '0;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rpt_valid = ~fifo_empty;
  assign rpt_ofs   = fifo_dout[OFS_W+N_STE-1:N_STE];
  assign rpt_vec   = fifo_dout[N_STE-1:0];
  assign active    = active_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_nfa_stream_engine.sv
// Bench for nfa_stream_engine. Two instances: A with default parameters and
// B with FIFO_DEPTH=2, OFS_W=4. Shared stimulus is steered to one instance by
// dut_sel; observed outputs are muxed back from the selected instance.
module tb_nfa_stream_engine;

  logic        clk, reset, dut_sel;
  logic        cfg_we, sym_valid, sym_last, rpt_ready;
  logic [1:0]  cfg_sel;
  logic [3:0]  cfg_ste;
  logic [1:0]  cfg_int;
  logic [16:0] cfg_wdata;
  logic [7:0]  sym_data;

  logic        a_cfg_err, a_sym_ready, a_rpt_valid, a_busy, a_done;
  logic [31:0] a_rpt_ofs;
  logic [15:0] a_rpt_vec, a_active;
  logic [1:0]  a_state;
  logic        b_cfg_err, b_sym_ready, b_rpt_valid, b_busy, b_done;
  logic [3:0]  b_rpt_ofs;
  logic [15:0] b_rpt_vec, b_active;
  logic [1:0]  b_state;

  logic        o_cfg_err, o_sym_ready, o_rpt_valid, o_busy, o_done;
  logic [31:0] o_rpt_ofs;
  logic [15:0] o_rpt_vec, o_active;
  logic [1:0]  o_state;

  nfa_stream_engine #(.N_STE(16), .SYM_W(8), .N_INT(4), .FIFO_DEPTH(8), .OFS_W(32)) u_dut_a (
    .clk(clk), .reset(reset), .cfg_we(cfg_we & ~dut_sel), .cfg_sel(cfg_sel), .cfg_ste(cfg_ste),
    .cfg_int(cfg_int), .cfg_wdata(cfg_wdata), .cfg_err(a_cfg_err),
    .sym_valid(sym_valid & ~dut_sel), .sym_ready(a_sym_ready), .sym_data(sym_data),
    .sym_last(sym_last), .rpt_valid(a_rpt_valid), .rpt_ready(rpt_ready & ~dut_sel),
    .rpt_ofs(a_rpt_ofs), .rpt_vec(a_rpt_vec), .active(a_active), .busy(a_busy),
    .done(a_done), .dbg_state(a_state));

  nfa_stream_engine #(.N_STE(16), .SYM_W(8), .N_INT(4), .FIFO_DEPTH(2), .OFS_W(4)) u_dut_b (
    .clk(clk), .reset(reset), .cfg_we(cfg_we & dut_sel), .cfg_sel(cfg_sel), .cfg_ste(cfg_ste),
    .cfg_int(cfg_int), .cfg_wdata(cfg_wdata), .cfg_err(b_cfg_err),
    .sym_valid(sym_valid & dut_sel), .sym_ready(b_sym_ready), .sym_data(sym_data),
    .sym_last(sym_last), .rpt_valid(b_rpt_valid), .rpt_ready(rpt_ready & dut_sel),
    .rpt_ofs(b_rpt_ofs), .rpt_vec(b_rpt_vec), .active(b_active), .busy(b_busy),
    .done(b_done), .dbg_state(b_state));

  assign o_cfg_err   = dut_sel ? b_cfg_err   : a_cfg_err;
  assign o_sym_ready = dut_sel ? b_sym_ready : a_sym_ready;
  assign o_rpt_valid = dut_sel ? b_rpt_valid : a_rpt_valid;
  assign o_rpt_ofs   = dut_sel ? {28'd0, b_rpt_ofs} : a_rpt_ofs;
  assign o_rpt_vec   = dut_sel ? b_rpt_vec   : a_rpt_vec;
  assign o_active    = dut_sel ? b_active    : a_active;
  assign o_busy      = dut_sel ? b_busy      : a_busy;
  assign o_done      = dut_sel ? b_done      : a_done;
  assign o_state     = dut_sel ? b_state     : a_state;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          m_lo [16][4];
  int          m_hi [16][4];
  bit          m_en [16][4];
  logic [15:0] m_pred [16];
  int          m_mode [16];
  bit          m_rep [16];
  logic [15:0] m_act;
  int          m_state;       // 0 idle, 1 stream, 2 drain
  longint      m_ofs;
  longint      ofs_mod;
  int          depth_cur;
  bit          done_pend, err_pend;
  logic [47:0] exp_q[$];      // scoreboard: expected {ofs, vec} records
  logic [47:0] pop_log[$];    // records actually popped from the DUT

  int n_checks, n_fail, n_done, n_err;
  bit acc_flag, rand_rdy;

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_pred[i] = '0; m_mode[i] = 0; m_rep[i] = 0;
      for (int k = 0; k < 4; k++) begin
        m_lo[i][k] = 0; m_hi[i][k] = 0; m_en[i][k] = 0;
      end
    end
    m_act = '0; m_state = 0; m_ofs = 0;
    done_pend = 0; err_pend = 0;
    exp_q.delete();
  endtask

  task automatic model_step(logic [7:0] sym, bit last, int st0);
    logic [15:0] nact, rep;
    longint o;
    o = (st0 == 0) ? 0 : m_ofs;
    for (int i = 0; i < 16; i++) begin
      bit hit, en;
      hit = 0;
      for (int k = 0; k < 4; k++)
        if (m_en[i][k] && int'(sym) >= m_lo[i][k] && int'(sym) <= m_hi[i][k]) hit = 1;
      en = ((m_act & m_pred[i]) != 0) || (st0 == 0 && m_mode[i] == 1) || (m_mode[i] == 2);
      nact[i] = hit && en;
      rep[i]  = nact[i] && m_rep[i];
    end
    if (rep != 0) exp_q.push_back({o[31:0], rep});
    m_act   = nact;
    m_ofs   = (o + 1) % ofs_mod;
    m_state = last ? 2 : 1;
  endtask

  // One clock: compare outputs at the negedge, advance the model, step past posedge.
  task automatic cycle();
    int st0;
    bit exp_rdy, drain_exit, new_err;
    @(negedge clk);
    st0     = m_state;
    exp_rdy = (st0 != 2) && (exp_q.size() < depth_cur);
    n_checks++;
    if (o_sym_ready !== exp_rdy) begin
      n_fail++; $display("FAIL sym_ready: got %b expected %b t=%0t", o_sym_ready, exp_rdy, $time);
    end
    n_checks++;
    if (o_rpt_valid !== (exp_q.size() != 0)) begin
      n_fail++; $display("FAIL rpt_valid: got %b expected %b t=%0t", o_rpt_valid, exp_q.size() != 0, $time);
    end
    n_checks++;
    if (o_active !== m_act) begin
      n_fail++; $display("FAIL active: got %h expected %h t=%0t", o_active, m_act, $time);
    end
    n_checks++;
    if (o_busy !== (st0 != 0)) begin
      n_fail++; $display("FAIL busy: got %b expected %b t=%0t", o_busy, st0 != 0, $time);
    end
    n_checks++;
    if (o_state !== st0[1:0]) begin
      n_fail++; $display("FAIL state: got %0d expected %0d t=%0t", o_state, st0, $time);
    end
    n_checks++;
    if (o_done !== done_pend) begin
      n_fail++; $display("FAIL done: got %b expected %b t=%0t", o_done, done_pend, $time);
    end
    n_checks++;
    if (o_cfg_err !== err_pend) begin
      n_fail++; $display("FAIL cfg_err: got %b expected %b t=%0t", o_cfg_err, err_pend, $time);
    end
    if (o_done) n_done++;
    if (o_cfg_err) n_err++;
    drain_exit = (st0 == 2) && (exp_q.size() == 0);
    new_err    = cfg_we && (st0 != 0 || cfg_sel == 2'd3);
    if (rpt_ready && exp_q.size() != 0) begin
      n_checks++;
      if ({o_rpt_ofs, o_rpt_vec} !== exp_q[0]) begin
        n_fail++; $display("FAIL record: got ofs=%0d vec=%h expected ofs=%0d vec=%h t=%0t",
                           o_rpt_ofs, o_rpt_vec, exp_q[0][47:16], exp_q[0][15:0], $time);
      end
      pop_log.push_back({o_rpt_ofs, o_rpt_vec});
      void'(exp_q.pop_front());
    end
    if (sym_valid && exp_rdy) begin
      model_step(sym_data, sym_last, st0);
      acc_flag = 1;
    end
    if (drain_exit) begin
      m_act = '0; m_state = 0;
    end
    if (cfg_we && st0 == 0 && cfg_sel != 2'd3) begin
      case (cfg_sel)
        2'd0: begin
          m_lo[cfg_ste][cfg_int] = int'(cfg_wdata[7:0]);
          m_hi[cfg_ste][cfg_int] = int'(cfg_wdata[15:8]);
          m_en[cfg_ste][cfg_int] = cfg_wdata[16];
        end
        2'd1: m_pred[cfg_ste] = cfg_wdata[15:0];
        default: begin
          m_mode[cfg_ste] = int'(cfg_wdata[1:0]);
          m_rep[cfg_ste]  = cfg_wdata[2];
        end
      endcase
    end
    done_pend = drain_exit;
    err_pend  = new_err;
    @(posedge clk);
    #1;
    if (rand_rdy) rpt_ready = 1'($urandom_range(0, 1));
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1; sym_valid = 0; sym_last = 0; cfg_we = 0;
    @(posedge clk);
    #1;
    reset = 0;
    model_clear();
  endtask

  task automatic select_dut(logic s);
    dut_sel   = s;
    depth_cur = s ? 2 : 8;
    ofs_mod   = s ? 64'd16 : 64'h1_0000_0000;
    do_reset();
  endtask

  task automatic cfg_write(logic [1:0] sel, logic [3:0] ste, logic [1:0] idx, logic [16:0] data);
    cfg_we = 1; cfg_sel = sel; cfg_ste = ste; cfg_int = idx; cfg_wdata = data;
    cycle();
    cfg_we = 0;
  endtask

  task automatic cfg_iv(logic [3:0] ste, logic [1:0] idx, bit en, logic [7:0] lo, logic [7:0] hi);
    cfg_write(2'd0, ste, idx, {en, hi, lo});
  endtask

  task automatic cfg_attr(logic [3:0] ste, logic [1:0] mode, bit rep);
    cfg_write(2'd2, ste, 2'd0, {14'd0, rep, mode});
  endtask

  task automatic send_sym(logic [7:0] d, bit last);
    int t;
    sym_valid = 1; sym_data = d; sym_last = last; acc_flag = 0; t = 0;
    while (!acc_flag && t < 200) begin
      cycle(); t++;
    end
    n_checks++;
    if (!acc_flag) begin
      n_fail++; $display("FAIL accept_timeout: got no acceptance expected one within 200 cycles");
    end
    sym_valid = 0; sym_last = 0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((m_state != 0 || done_pend) && t < 300) begin
      cycle(); t++;
    end
    n_checks++;
    if (t >= 300) begin
      n_fail++; $display("FAIL idle_timeout: got state %0d expected idle within 300 cycles", m_state);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    select_dut(0);
    @(negedge clk);
    n_checks++;
    if ({o_active, o_rpt_valid, o_busy, o_done, o_cfg_err, o_sym_ready} !== {16'h0, 5'b00001}) begin
      n_fail++; $display("FAIL reset_values: got act=%h rv=%b busy=%b done=%b err=%b rdy=%b expected 0,0,0,0,0,1",
                         o_active, o_rpt_valid, o_busy, o_done, o_cfg_err, o_sym_ready);
    end
    @(posedge clk); #1;
    repeat (3) cycle();
  endtask

  task automatic test_sod_single();
    int d0;
    select_dut(0);
    pop_log.delete(); rpt_ready = 0; d0 = n_done;
    cfg_iv(0, 0, 1, 8'd0, 8'd0);
    cfg_attr(0, 2'd1, 1);
    send_sym(8'd0, 0);
    send_sym(8'd0, 1);
    repeat (3) cycle();
    rpt_ready = 1;
    wait_idle();
    cycle();
    n_checks++;
    if (pop_log.size() != 1 || pop_log[0] !== {32'd0, 16'h0001}) begin
      n_fail++; $display("FAIL sod_record: got %0d records first=%h expected 1 record 000000000001",
                         pop_log.size(), pop_log.size() ? pop_log[0] : 48'h0);
    end
    n_checks++;
    if (n_done - d0 !== 1 || o_active !== 16'h0) begin
      n_fail++; $display("FAIL sod_done: got done=%0d active=%h expected 1 and 0000", n_done - d0, o_active);
    end
  endtask

  task automatic test_chain();
    select_dut(0);
    pop_log.delete(); rpt_ready = 1;
    cfg_iv(0, 0, 1, 8'd0, 8'd0);   cfg_attr(0, 2'd1, 0);
    cfg_iv(1, 0, 1, 8'd8, 8'd15);  cfg_write(2'd1, 1, 0, 17'h00001); cfg_attr(1, 2'd0, 1);
    cfg_iv(2, 0, 1, 8'd0, 8'd15);  cfg_write(2'd1, 2, 0, 17'h00004); cfg_attr(2, 2'd2, 0);
    send_sym(8'd0, 0);
    send_sym(8'd9, 0);
    send_sym(8'd3, 1);
    n_checks++;
    if (o_active !== 16'h0004) begin
      n_fail++; $display("FAIL chain_active: got %h expected 0004", o_active);
    end
    wait_idle();
    n_checks++;
    if (pop_log.size() != 1 || pop_log[0] !== {32'd1, 16'h0002}) begin
      n_fail++; $display("FAIL chain_record: got %0d records first=%h expected 1 record 000000010002",
                         pop_log.size(), pop_log.size() ? pop_log[0] : 48'h0);
    end
  endtask

  task automatic test_back_pressure();
    select_dut(1);
    pop_log.delete(); rpt_ready = 0;
    cfg_iv(0, 0, 1, 8'd0, 8'd255);
    cfg_attr(0, 2'd2, 1);
    send_sym(8'd10, 0);
    send_sym(8'd20, 0);
    n_checks++;
    if (o_sym_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_ready: got %b expected 0", o_sym_ready);
    end
    sym_valid = 1; sym_data = 8'd30; sym_last = 1; acc_flag = 0;
    repeat (4) cycle();
    n_checks++;
    if (acc_flag !== 1'b0) begin
      n_fail++; $display("FAIL bp_stall: got accepted=%b expected 0", acc_flag);
    end
    rpt_ready = 1;
    send_sym(8'd30, 1);
    wait_idle();
    n_checks++;
    if (pop_log.size() != 3 || pop_log[0] !== {32'd0, 16'h1} || pop_log[1] !== {32'd1, 16'h1} ||
        pop_log[2] !== {32'd2, 16'h1}) begin
      n_fail++; $display("FAIL bp_records: got %0d records expected ofs 0,1,2 vec 0001", pop_log.size());
    end
  endtask

  task automatic test_cfg_lockout();
    int e0;
    select_dut(0);
    pop_log.delete(); rpt_ready = 1;
    cfg_iv(0, 0, 1, 8'd5, 8'd5);
    cfg_attr(0, 2'd2, 1);
    e0 = n_err;
    send_sym(8'd5, 0);
    cfg_iv(0, 0, 1, 8'd7, 8'd7);
    cycle();
    n_checks++;
    if (n_err - e0 !== 1) begin
      n_fail++; $display("FAIL lockout_err: got %0d pulses expected 1", n_err - e0);
    end
    send_sym(8'd7, 0);
    send_sym(8'd5, 1);
    wait_idle();
    n_checks++;
    if (pop_log.size() != 2 || pop_log[0] !== {32'd0, 16'h1} || pop_log[1] !== {32'd2, 16'h1}) begin
      n_fail++; $display("FAIL lockout_records: got %0d records expected ofs 0 and 2", pop_log.size());
    end
    e0 = n_err;
    cfg_write(2'd3, 0, 0, 17'h1ffff);
    cycle();
    n_checks++;
    if (n_err - e0 !== 1) begin
      n_fail++; $display("FAIL sel3_err: got %0d pulses expected 1", n_err - e0);
    end
  endtask

  task automatic test_reset_mid();
    select_dut(0);
    rpt_ready = 0;
    cfg_iv(0, 0, 1, 8'd0, 8'd255);
    cfg_attr(0, 2'd2, 1);
    send_sym(8'd1, 0);
    send_sym(8'd2, 0);
    do_reset();
    @(negedge clk);
    n_checks++;
    if ({o_rpt_valid, o_busy, o_active} !== 18'h0) begin
      n_fail++; $display("FAIL reset_mid: got rv=%b busy=%b act=%h expected 0,0,0000", o_rpt_valid, o_busy, o_active);
    end
    @(posedge clk); #1;
    pop_log.delete(); rpt_ready = 1;
    send_sym(8'd0, 1);
    n_checks++;
    if (o_active !== 16'h0) begin
      n_fail++; $display("FAIL reset_cfg_cleared: got %h expected 0000", o_active);
    end
    wait_idle();
    cfg_iv(0, 0, 1, 8'd0, 8'd0);
    cfg_attr(0, 2'd1, 1);
    send_sym(8'd0, 1);
    wait_idle();
    n_checks++;
    if (pop_log.size() != 1 || pop_log[0] !== {32'd0, 16'h1}) begin
      n_fail++; $display("FAIL reset_restart: got %0d records expected 1 record ofs 0 vec 0001", pop_log.size());
    end
  endtask

  task automatic test_ofs_wrap();
    select_dut(1);
    pop_log.delete(); rpt_ready = 1;
    cfg_iv(0, 0, 1, 8'd0, 8'd255);
    cfg_attr(0, 2'd2, 1);
    for (int s = 0; s < 18; s++) send_sym(8'($urandom_range(0, 255)), s == 17);
    wait_idle();
    n_checks++;
    if (pop_log.size() != 18 || pop_log[15][47:16] !== 32'd15 || pop_log[16][47:16] !== 32'd0 ||
        pop_log[17][47:16] !== 32'd1) begin
      n_fail++; $display("FAIL ofs_wrap: got %0d records expected 18 with ofs 15,0,1 at 16th..18th", pop_log.size());
    end
  endtask

  task automatic test_random();
    for (int d = 0; d < 2; d++) begin
      select_dut(1'(d));
      for (int s = 0; s < 4; s++) begin
        int len;
        rand_rdy = 1;
        for (int i = 0; i < 16; i++) begin
          for (int k = 0; k < 4; k++) begin
            int lo, hi;
            lo = $urandom_range(0, 255);
            hi = lo + $urandom_range(0, 90);
            if (hi > 255) hi = 255;
            if ($urandom_range(0, 7) == 0) begin
              int t; t = lo; lo = hi; hi = t;
            end
            cfg_iv(4'(i), 2'(k), $urandom_range(0, 3) != 0, 8'(lo), 8'(hi));
          end
          cfg_write(2'd1, 4'(i), 0, 17'((1 << $urandom_range(0, 15)) | (1 << $urandom_range(0, 15))));
          cfg_attr(4'(i), 2'($urandom_range(0, 3)), $urandom_range(0, 2) == 0);
        end
        if ($urandom_range(0, 1)) cfg_write(2'd3, 4'($urandom_range(0, 15)), 0, 17'($urandom));
        len = $urandom_range(10, 30);
        for (int n = 0; n < len; n++) begin
          repeat ($urandom_range(0, 2)) cycle();
          if ($urandom_range(0, 15) == 0)
            cfg_write(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 17'($urandom));
          send_sym(8'($urandom_range(0, 255)), n == len - 1);
        end
        rand_rdy = 0; rpt_ready = 1;
        wait_idle();
      end
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; n_done = 0; n_err = 0;
    acc_flag = 0; rand_rdy = 0;
    reset = 1; dut_sel = 0; cfg_we = 0; cfg_sel = 0; cfg_ste = 0; cfg_int = 0; cfg_wdata = 0;
    sym_valid = 0; sym_data = 0; sym_last = 0; rpt_ready = 0;
    depth_cur = 8; ofs_mod = 64'h1_0000_0000;
    model_clear();
    test_reset();
    test_sod_single();
    test_chain();
    test_back_pressure();
    test_cfg_lockout();
    test_reset_mid();
    test_ofs_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
